// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the caches/memory view.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0;
  logic            req1;
  logic            we0;
  logic            we1;
  logic [XLEN-1:0] addr0;
  logic [XLEN-1:0] addr1;
  logic [XLEN-1:0] wdata0;
  logic [XLEN-1:0] wdata1;
  logic            done0;
  logic            done1;
  logic            err;
  logic [XLEN-1:0] rdata;
  logic            busy;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output done0, done1, err, rdata, busy,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  done0, done1, err, rdata, busy,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory port between data cache (0) and fetch (1).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t          r_state;
  logic            r_owner;
  logic [15:0]     r_wdog;
  logic            r_done0;
  logic            r_done1;
  logic            r_err;
  logic [XLEN-1:0] r_rdata;
  logic            r_busy;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;

  logic            w_grant;
  logic            w_we;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_wdata;

`ifdef MEM_ARB_RR_EN
  logic r_last;

  // Winner select: on a tie the port not granted last time wins
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0 && bus.req1) begin
      w_grant = ~r_last;
    end else if (bus.req1) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end
`else
  // Winner select: port 0 always wins when it requests
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0) begin
      w_grant = 1'b0;
    end else begin
      w_grant = 1'b1;
    end
  end
`endif

  // Command mux for the winning port
  always_comb begin
    w_we    = 1'b0;
    w_addr  = {XLEN{1'b0}};
    w_wdata = {XLEN{1'b0}};
    if (w_grant) begin
      w_we    = bus.we1;
      w_addr  = bus.addr1;
      w_wdata = bus.wdata1;
    end else begin
      w_we    = bus.we0;
      w_addr  = bus.addr0;
      w_wdata = bus.wdata0;
    end
  end

  // Arbitration FSM; all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_wdog      <= 16'd0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= {XLEN{1'b0}};
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {XLEN{1'b0}};
      r_mem_wdata <= {XLEN{1'b0}};
`ifdef MEM_ARB_RR_EN
      r_last      <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          if (bus.req0 || bus.req1) begin
            r_owner     <= w_grant;
            r_mem_we    <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_wdog      <= 16'd0;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_BUSY;
`ifdef MEM_ARB_RR_EN
            r_last      <= w_grant;
`endif
          end
        end
        ST_BUSY: begin
          // mem_ready takes precedence over a coincident watchdog expiry
          if (bus.mem_ready) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= r_mem_we ? {XLEN{1'b0}} : bus.mem_rdata;
            r_done0   <= ~r_owner;
            r_done1   <= r_owner;
            r_state   <= ST_RESP;
          end else if (r_wdog == WDOG_LAST) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_rdata   <= {XLEN{1'b0}};
            r_done0   <= ~r_owner;
            r_done1   <= r_owner;
            r_state   <= ST_RESP;
          end else begin
            r_wdog    <= r_wdog + 16'd1;
          end
        end
        ST_RESP: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done0   <= 1'b0;
          r_done1   <= 1'b0;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.done0     = r_done0;
  assign bus.done1     = r_done1;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = r_busy;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter (TIMEOUT=8); the expected grant
// order follows MEM_ARB_RR_EN exactly as the design is built.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          nreq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input int port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic err, input int nreq);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.err = err; e.nreq = nreq;
    sb.push_back(e);
  endtask

  task automatic drive(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  // Memory model plus completion check; lat = 0 means memory never answers
  task automatic serve(input int lat, input logic [31:0] mdata, input bit drop);
    exp_t e;
    int   cyc  = 0;
    int   nreq = 0;
    bit   got  = 1'b0;
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      while (!got && cyc < 60) begin
        @(negedge clk);
        cyc++;
        bus.mem_ready = 1'b0;
        if (bus.done0 || bus.done1) begin
          got = 1'b1;
        end else if (bus.mem_req) begin
          nreq++;
          check("mem_addr", bus.mem_addr, e.addr);
          check("mem_we", 32'(bus.mem_we), 32'(e.we));
          check("mem_wdata", bus.mem_wdata, e.wdata);
          if (nreq == lat) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mdata;
          end
        end
      end
      check("done_seen", 32'(got), 32'd1);
      if (got) begin
        check("done0", 32'(bus.done0), 32'(e.port == 0));
        check("done1", 32'(bus.done1), 32'(e.port == 1));
        check("err", 32'(bus.err), 32'(e.err));
        check("rdata", bus.rdata, e.rdata);
        check("busy_resp", 32'(bus.busy), 32'd1);
        check("mem_req_cycles", 32'(nreq), 32'(e.nreq));
        check("latency", 32'(cyc), 32'(e.nreq + 1));
        if (drop) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
        @(negedge clk);
        check("done0_pulse", 32'(bus.done0), 32'd0);
        check("done1_pulse", 32'(bus.done1), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("rdata_hold", bus.rdata, e.rdata);
      end
    end
  endtask

  initial begin
    int ord[4];
    rst = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 32'd0; bus.addr1 = 32'd0; bus.wdata0 = 32'd0; bus.wdata1 = 32'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_done0", 32'(bus.done0), 32'd0);
    check("rst_done1", 32'(bus.done1), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single read on port 0, three-cycle memory
    drive(0, 1'b0, 32'h0000_0100, 32'd0);
    expect_txn(0, 1'b0, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1'b0, 3);
    serve(3, 32'hDEAD_BEEF, 1'b1);

    // Write on port 1, single-cycle memory; writes return zero
    drive(1, 1'b1, 32'h0000_0040, 32'h1234_5678);
    expect_txn(1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'd0, 1'b0, 1);
    serve(1, 32'hA5A5_A5A5, 1'b1);

    // Both ports held for four back-to-back transactions
`ifdef MEM_ARB_RR_EN
    ord = '{0, 1, 0, 1};
`else
    ord = '{0, 0, 0, 0};
`endif
    drive(0, 1'b0, 32'h0000_0200, 32'd0);
    drive(1, 1'b0, 32'h0000_0300, 32'd0);
    for (int i = 0; i < 4; i++) begin
      expect_txn(ord[i], 1'b0, (ord[i] == 1) ? 32'h0000_0300 : 32'h0000_0200, 32'd0,
                 32'h1000_0000 + 32'(i), 1'b0, 1);
    end
    for (int i = 0; i < 4; i++) begin
      serve(1, 32'h1000_0000 + 32'(i), i == 3);
    end

    // Watchdog abort, then a normal transaction
    drive(0, 1'b0, 32'h0000_0080, 32'd0);
    expect_txn(0, 1'b0, 32'h0000_0080, 32'd0, 32'd0, 1'b1, 8);
    serve(0, 32'h55AA_55AA, 1'b1);
    drive(1, 1'b0, 32'h0000_0084, 32'd0);
    expect_txn(1, 1'b0, 32'h0000_0084, 32'd0, 32'hCAFE_F00D, 1'b0, 2);
    serve(2, 32'hCAFE_F00D, 1'b1);

    // mem_ready on the last watchdog cycle wins over the timeout
    drive(0, 1'b0, 32'h0000_0088, 32'd0);
    expect_txn(0, 1'b0, 32'h0000_0088, 32'd0, 32'h0BAD_F00D, 1'b0, 8);
    serve(8, 32'h0BAD_F00D, 1'b1);

    // Reset in the second BUSY cycle abandons the transaction
    drive(0, 1'b0, 32'h0000_0090, 32'd0);
    @(negedge clk);
    check("abort_mem_req_busy", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.req0 = 1'b0;
    @(negedge clk);
    check("abort_mem_req", 32'(bus.mem_req), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done0", 32'(bus.done0), 32'd0);
    check("abort_done1", 32'(bus.done1), 32'd0);
    rst = 1'b1;
    drive(0, 1'b0, 32'h0000_00A0, 32'd0);
    drive(1, 1'b0, 32'h0000_00B0, 32'd0);
    expect_txn(0, 1'b0, 32'h0000_00A0, 32'd0, 32'h600D_CAFE, 1'b0, 1);
    serve(1, 32'h600D_CAFE, 1'b1);

    // Stray mem_ready while idle is ignored
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("stray_done0", 32'(bus.done0), 32'd0);
    check("stray_done1", 32'(bus.done1), 32'd0);
    check("stray_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single main-memory port between the data cache (port 0) and the instruction fetch/cache path (port 1). It sits between both caches and main memory. It latches one request at a time, drives the multi-cycle memory handshake and returns read data to the granted requester with a one-cycle done pulse. A watchdog aborts transactions that memory never completes.

## Interface
- `XLEN`, 32, address and data width
- `TIMEOUT`, 255, maximum BUSY cycles before abort (1..65535); watchdog counter is 16 bits
- `clk` in 1 — single clock, all logic on posedge
- `rst` in 1 — synchronous, active-low reset (asserted when 0)
- `req0`, `req1` in 1 — request from port 0 (data cache) / port 1 (fetch)
- `we0`, `we1` in 1 — 1 = write, 0 = read
- `addr0`, `addr1` in XLEN — word-aligned byte address
- `wdata0`, `wdata1` in XLEN — write data
- `done0`, `done1` out 1 — one-cycle completion pulse per port
- `err` out 1 — high with a done pulse when the transaction timed out
- `rdata` out XLEN — read data, valid while a done pulse is high
- `busy` out 1 — high in BUSY and RESP
- `mem_req` out 1 — memory request, held until `mem_ready`
- `mem_we` out 1, `mem_addr` out XLEN, `mem_wdata` out XLEN — memory command
- `mem_ready` in 1 — memory completion strobe
- `mem_rdata` in XLEN — sampled when `mem_ready`=1

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if `req0|req1`, pick a winner, latch its `we`/`addr`/`wdata` into command registers, set owner bit, clear watchdog, go to BUSY. Otherwise stay.
- BUSY: `mem_req`=1 with latched command, which stays stable for the whole state. The watchdog increments each cycle.
  - On `mem_ready`: latch `mem_rdata` (reads only; writes return 0), go to RESP.
  - On watchdog == TIMEOUT-1 without `mem_ready`: set `err`, `rdata`=0, go to RESP.
  - If `mem_ready` and timeout occur in the same cycle, `mem_ready` wins and `err`=0.
- RESP: pulse `done[owner]` for exactly one cycle, return to IDLE. `err` is only valid in RESP.
- Requesters hold `req` until their done pulse. A request that drops during BUSY is still completed and its done pulse still fires.
- Requests arriving during BUSY/RESP are not latched. They are evaluated again on the next IDLE cycle.
- `mem_ready` outside BUSY is ignored.
- Reset has priority in every state. Reset mid-BUSY abandons the transaction immediately with no done pulse and `mem_req` low the next cycle; memory must tolerate the abandoned request.

## Timing
- Reset values: state IDLE, `done0`=`done1`=0, `err`=0, `rdata`=0, `busy`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, owner=0, last-grant=1 (so port 0 wins the first tie), watchdog=0.
- `req` seen at edge t gives `mem_req` high from t+1. `mem_ready` at cycle k gives done high in cycle k+1.
- Minimum latency is req → done in 2 cycles with a single-cycle memory.
- Back-to-back transactions from a held request are separated by one IDLE cycle, so the minimum period is 3 cycles.
- The done pulse is exactly one cycle. `rdata` and `err` hold their values until the next RESP.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - On a simultaneous request, the port not granted last wins. Last-grant updates on every grant.
  - A lone requester always wins.
- Not defined: fixed priority.
  - Port 0 (data cache) always wins a tie; port 1 may starve.
  - The last-grant register is not implemented.

## Test plan
- Single read port 0: `addr0`=0x100, memory returns 0xDEADBEEF after 3 cycles → `mem_req` high 3 cycles with `mem_addr`=0x100; `done0`=1 one cycle with `rdata`=0xDEADBEEF, `err`=0, `done1`=0.
- Write port 1: `we1`=1, `addr1`=0x40, `wdata1`=0x12345678, ready after 1 cycle → `mem_we`=1, `mem_wdata`=0x12345678; `done1` at cycle 2 after request; `rdata`=0.
- Simultaneous held requests, four transactions → with `MEM_ARB_RR_EN`: grant order 0,1,0,1. Without: 0,0,0,0.
- Timeout: `TIMEOUT`=8, `mem_ready` never asserted → done pulse after 8 BUSY cycles with `err`=1, `rdata`=0. The next request proceeds normally.
- Ready/timeout collision: `mem_ready` on the 8th BUSY cycle with `TIMEOUT`=8 → `err`=0 and the memory data is returned.
- Reset mid-BUSY: `rst`=0 during cycle 2 of BUSY → next cycle state IDLE, `mem_req`=0, no done pulse. After release, the first tie goes to port 0.
